// File: rtl/core_seq_if.sv
// Shared instruction/data memory bus between the sequencer and the memory.
// Latency: wires only, no storage.
// Backpressure: the memory holds off the sequencer by withholding i_bus_ack.
interface core_seq_if #(
    parameter int XLEN = 32
);
    logic            o_bus_req;
    logic            o_bus_sel;
    logic            o_bus_we;
    logic            i_bus_ack;
    logic [XLEN-1:0] i_bus_rdata;

    // Sequencer side: drives the request, sees the completion.
    modport master (
        output o_bus_req, o_bus_sel, o_bus_we,
        input  i_bus_ack, i_bus_rdata
    );

    // Memory side: sees the request, drives the completion.
    modport slave (
        input  o_bus_req, o_bus_sel, o_bus_we,
        output i_bus_ack, i_bus_rdata
    );
endinterface

// File: rtl/core_seq.sv
// Multi-cycle RV32I sequencer: fetch, execute, optional memory phase, commit once.
// Latency: 2 cycles for ALU/branch/jump, 3 cycles for load/store with a zero-wait bus.
// Backpressure: waits on i_bus_ack while requesting; traps after TIMEOUT unacked cycles.
module core_seq #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 32
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_run,
    input  logic             i_reg_w_en,
    core_seq_if.master       bus,
    output logic [XLEN-1:0]  o_ir,
    output logic             o_pc_we,
    output logic             o_reg_we,
    output logic [1:0]       o_state,
    output logic             o_trap,
    output logic [1:0]       o_trap_cause,
    output logic [CNT_W-1:0] o_instret
);
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EXEC  = 2'd1,
        MEM   = 2'd2,
        TRAP  = 2'd3
    } state_t;

    localparam logic [7:0]      WAIT_LAST = 8'(TIMEOUT - 1);
    localparam logic [XLEN-1:0] NOP       = XLEN'(32'h0000_0013);

    state_t     state, state_nxt;
    logic [7:0] wait_cnt;
    logic       req, sel, we, pc_we, reg_we;
    logic       ir_load, cnt_clr, cnt_inc;
    logic [1:0] cause_nxt;
    logic [6:0] opcode;
    logic       is_load, is_store, is_legal;

    assign opcode   = o_ir[6:0];
    assign is_load  = (opcode == 7'b0000011);
    assign is_store = (opcode == 7'b0100011);

    // Opcode legality check on the latched instruction.
    always_comb begin
        is_legal = 1'b0;
        case (opcode)
            7'b0010011, 7'b0110011, 7'b0100011, 7'b0000011, 7'b1101111,
            7'b1100111, 7'b1100011, 7'b0110111, 7'b0010111: is_legal = 1'b1;
            default:                                        is_legal = 1'b0;
        endcase
    end

    // Next-state, bus request and commit strobes; reset masks every strobe in its own cycle.
    always_comb begin
        state_nxt = state;
        req       = 1'b0;
        sel       = 1'b0;
        we        = 1'b0;
        pc_we     = 1'b0;
        reg_we    = 1'b0;
        ir_load   = 1'b0;
        cnt_clr   = 1'b0;
        cnt_inc   = 1'b0;
        cause_nxt = o_trap_cause;
        case (state)
            FETCH: begin
                req = i_run;
                if (i_run) begin
                    if (bus.i_bus_ack) begin
                        ir_load   = 1'b1;
                        cnt_clr   = 1'b1;
                        state_nxt = EXEC;
                    end else if (wait_cnt == WAIT_LAST) begin
                        cnt_clr   = 1'b1;
                        cause_nxt = 2'd1;
                        state_nxt = TRAP;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            EXEC: begin
                if (!is_legal) begin
                    cause_nxt = 2'd2;
                    state_nxt = TRAP;
                end else if (is_load || is_store) begin
                    state_nxt = MEM;
                end else begin
                    pc_we     = 1'b1;
                    reg_we    = i_reg_w_en;
                    state_nxt = FETCH;
                end
            end
            MEM: begin
                req = 1'b1;
                sel = 1'b1;
                we  = is_store;
                if (bus.i_bus_ack) begin
                    pc_we     = 1'b1;
                    reg_we    = is_load & i_reg_w_en;
                    cnt_clr   = 1'b1;
                    state_nxt = FETCH;
                end else if (wait_cnt == WAIT_LAST) begin
                    cnt_clr   = 1'b1;
                    cause_nxt = 2'd1;
                    state_nxt = TRAP;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            default: begin
                state_nxt = TRAP;
            end
        endcase
        if (i_rst) begin
            req    = 1'b0;
            we     = 1'b0;
            pc_we  = 1'b0;
            reg_we = 1'b0;
        end
    end

    // State, instruction register, wait counter, trap cause and retire counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state        <= FETCH;
            o_ir         <= NOP;
            wait_cnt     <= 8'd0;
            o_trap_cause <= 2'd0;
            o_instret    <= '0;
        end else begin
            state        <= state_nxt;
            o_trap_cause <= cause_nxt;
            if (ir_load) begin
                o_ir <= bus.i_bus_rdata;
            end
            if (cnt_clr) begin
                wait_cnt <= 8'd0;
            end else if (cnt_inc) begin
                wait_cnt <= wait_cnt + 8'd1;
            end
            if (pc_we) begin
                o_instret <= o_instret + 1'b1;
            end
        end
    end

    assign bus.o_bus_req = req;
    assign bus.o_bus_sel = sel;
    assign bus.o_bus_we  = we;
    assign o_pc_we       = pc_we;
    assign o_reg_we      = reg_we;
    assign o_state       = state;
    assign o_trap        = (state == TRAP);
endmodule

// File: doc/core_seq.md
Name: core_seq

Overview:
- Multi-cycle sequencer for the RV32I core.
- Shares one memory bus between instruction fetch and load/store data access.
- Latches the instruction register and gates the PC and register-file write strobes so that each instruction commits exactly once.
- Sits between the instruction/data memory, the control decoder (which supplies reg-write intent) and the PC/regfile.

Parameters:
- XLEN, 32, datapath and bus data width.
- TIMEOUT, 16, maximum bus wait cycles before trap; legal range 2..255.
- CNT_W, 32, width of retired-instruction counter.

Ports:
- i_clk  input  1  core clock; all state changes on rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_run  input  1  1 = allow new fetches; 0 = idle in FETCH.
- i_reg_w_en  input  1  decoder register-write intent for current instruction.
- i_bus_ack  input  1  bus completes current request this cycle.
- i_bus_rdata  input  XLEN  bus read data, valid when i_bus_ack=1.
- o_bus_req  output  1  bus request.
- o_bus_sel  output  1  bus address source: 0 = PC, 1 = ALU result.
- o_bus_we  output  1  bus write enable (stores).
- o_ir  output  XLEN  latched instruction.
- o_pc_we  output  1  PC register update strobe.
- o_reg_we  output  1  regfile write strobe.
- o_state  output  2  FETCH=0, EXEC=1, MEM=2, TRAP=3.
- o_trap  output  1  core halted.
- o_trap_cause  output  2  0 none, 1 bus timeout, 2 illegal opcode.
- o_instret  output  CNT_W  retired-instruction count.

Behaviour:
- Reset (cycle with i_rst=1):
  - Next state FETCH; o_ir <= 32'h00000013 (NOP); o_instret <= 0; o_trap/o_trap_cause <= 0; wait counter <= 0.
  - o_bus_req, o_bus_we, o_pc_we and o_reg_we are forced 0 combinationally in that same cycle.
  - Reset mid-transaction drops the request immediately; no commit occurs.
- Opcode field is o_ir[6:0].
  - Load = 0000011; store = 0100011.
  - Legal opcodes: 0010011, 0110011, 0100011, 0000011, 1101111, 1100111, 1100011, 0110111, 0010111. Any other opcode is illegal.
- FETCH:
  - o_bus_req = i_run; o_bus_sel = 0; o_bus_we = 0.
  - On req & ack: o_ir <= i_bus_rdata; wait counter <= 0; -> EXEC.
  - On req & !ack: wait counter increments. The cycle where the counter equals TIMEOUT-1 with no ack -> TRAP, cause 1.
  - i_run=0: counter holds, state holds.
- EXEC (exactly 1 cycle; decoder/ALU settle from o_ir):
  - Illegal opcode: -> TRAP, cause 2; no strobes.
  - Load/store: -> MEM; no strobes.
  - Otherwise: o_pc_we = 1; o_reg_we = i_reg_w_en; o_instret increments; -> FETCH.
- MEM:
  - o_bus_req = 1; o_bus_sel = 1; o_bus_we = is_store.
  - Address and write data are held stable by the datapath while req is high.
  - On ack: o_pc_we = 1; o_reg_we = is_load & i_reg_w_en (regfile captures i_bus_rdata the same cycle); o_instret increments; wait counter <= 0; -> FETCH.
  - Timeout rule is identical to FETCH (i_run is ignored in MEM).
- TRAP:
  - All strobes and o_bus_req are 0; o_trap = 1; o_trap_cause held.
  - Only i_rst exits TRAP.
- Timing and boundary rules:
  - Ack arriving in the same cycle as req is legal (zero-wait bus).
  - Minimum latency: 2 cycles for ALU/branch/jump instructions, 3 cycles for load/store.
  - Ack and timeout in the same cycle: ack wins.
  - i_bus_ack while o_bus_req=0 is ignored.
  - o_instret wraps from 2^CNT_W-1 to 0.
  - o_pc_we and o_reg_we are single-cycle pulses; never both asserted outside the commit cycle.

Test Plan:
- Reset, i_run=1, zero-wait bus returning 0x00500093 (ADDI) -> state sequence 0,1,0; o_pc_we and o_reg_we pulse in cycle 2; o_instret=1; o_ir=0x00500093.
- LW 0x0000A103, ack delayed 3 cycles in MEM -> o_bus_sel=1, o_bus_we=0 held 4 cycles; commit pulse on the ack cycle; o_reg_we=1.
- SW 0x0020A023 -> o_bus_we=1 only in MEM; o_reg_we=0; o_pc_we=1 on ack.
- Fetch returning 0x0000007F -> TRAP in the cycle after EXEC; o_trap_cause=2; no pc/reg strobes; stays in TRAP until i_rst.
- No ack, TIMEOUT=16 -> TRAP after 16 req cycles, cause 1. Repeat with ack on exactly the 16th cycle -> no trap.
- i_rst asserted during MEM wait -> o_bus_req=0 that cycle; then FETCH with o_ir=0x13 and o_instret=0. Separately, i_run=0 in FETCH -> o_bus_req=0 and the state holds.
